fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32IM pipeline, directly upstream of the decode stage.
- Holds the PC and issues in-order requests to instruction memory over a valid/ready handshake.
- Buffers returned words in a small queue and drives the IF/ID pipeline register that decode consumes.
- Handles hazard stalls, IF/ID flushes and branch/jump redirects. In-flight responses from the old instruction stream are discarded.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- DEPTH, 2, response queue depth and in-flight credit limit. Power of two, range 2..8.
- NOP_INSTR, 32'h0000_0013, encoding driven on id_instr when the slot is invalid (addi x0,x0,0).

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  32  fetch address (word aligned)
- imem_rsp_valid  input  1  response valid; responses return in request order
- imem_rsp_data  input  32  instruction word
- stall  input  1  hazard unit: hold IF/ID contents
- flush  input  1  squash IF/ID (insert bubble)
- redirect_valid  input  1  branch/jump taken, restart fetch
- redirect_pc  input  32  new fetch PC; bits [1:0] ignored and forced to 0
- id_valid  output  1  IF/ID holds a real instruction
- id_pc  output  32  PC of id_instr
- id_pc_plus4  output  32  id_pc + 4
- id_instr  output  32  instruction to decode

Behaviour:
- Reset (async, while rst=1):
  - pc=RESET_PC; outstanding=0, drop_cnt=0, queue empty.
  - imem_req_valid=0, id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_pc_plus4=4.
- Request issue:
  - imem_req_valid = !rst && !redirect_valid && (outstanding + q_count < DEPTH).
  - imem_req_valid must not depend combinationally on imem_req_ready.
  - imem_req_addr = pc.
  - On accept (valid && ready): pc <= pc+4 (mod 2^32, wraps silently); outstanding++.
- Response:
  - Each imem_rsp_valid decrements outstanding.
  - A response with outstanding==0 is illegal; the bench asserts on it.
  - Response PC is tracked with a parallel PC queue, or by recomputing from a response-PC register that increments per kept response.
- Drop:
  - A response arriving while drop_cnt>0 is discarded and decrements drop_cnt.
  - A response arriving in a redirect_valid cycle is also discarded.
- Redirect (redirect_valid=1), at the clock edge:
  - pc <= {redirect_pc[31:2],2'b00}; queue cleared.
  - drop_cnt <= outstanding - imem_rsp_valid.
  - No request is issued in the redirect cycle. Fetch from the new PC starts the next cycle.
- IF/ID update, priority flush > stall > advance:
  - flush: id_valid<=0, id_instr<=NOP_INSTR, id_pc/id_pc_plus4 hold. Queue is not popped.
  - stall (no flush): all id_* hold. Queue is not popped; kept responses still enqueue.
  - Advance, queue non-empty: load the head {pc,instr}, pop, id_valid<=1.
  - Advance, queue empty with a kept response this cycle: bypass it directly into IF/ID (no enqueue), id_valid<=1.
  - Advance, nothing available: id_valid<=0, id_instr<=NOP_INSTR.
- Queue:
  - Simultaneous push and pop are allowed.
  - Push into a full queue cannot occur because of the credit rule; assert it.
  - A redirect clears the queue even if a push or pop occurs in the same cycle.
- Timing:
  - Zero-wait memory (response the cycle after accept, ready=1): request accepted in cycle t gives id_valid=1 with that instruction in cycle t+2.
  - Sustained throughput is one instruction per cycle.
- Reset mid-operation: all state returns to reset values immediately. Responses arriving after reset release with outstanding==0 are illegal (memory is reset too).

Test Plan:
- Reset release, ready=1, 1-cycle memory returning addr as data → id_pc 0,4,8,… on consecutive cycles from cycle 2; id_instr==id_pc; id_pc_plus4 correct.
- stall=1 for 3 cycles mid-stream → id_* frozen; no request while outstanding+q_count=2; after release the sequence resumes with no skipped or duplicated PC.
- redirect_valid with redirect_pc=32'h100 while 2 requests are in flight → both old responses dropped; next id_valid instruction has id_pc=32'h100.
- flush=1 and stall=1 together → id_valid=0, id_instr=32'h13 next cycle; queue contents preserved and delivered after release.
- imem_req_ready held low 5 cycles → imem_req_addr stable; no pc advance; id_valid=0 after the queue drains.
- Redirect to 32'h0000_0203 → fetch address 32'h200. pc at 32'hFFFF_FFFC followed by an accept → next address 32'h0.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32IM instruction-fetch stage: PC, imem requests, response queue, IF/ID register
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_instr
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   redirect_pc_aligned;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] q_count;
    logic [PW-1:0] q_head;
    logic [PW-1:0] q_tail;
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];

    logic req_fire;
    logic rsp_keep;
    logic q_empty;
    logic advance;
    logic q_push;
    logic q_pop;

    // Credit rule: in-flight requests plus buffered words never exceed the queue depth,
    // so every response is guaranteed a slot.
    assign imem_req_valid = !rst && !redirect_valid &&
                            (({1'b0, outstanding} + {1'b0, q_count}) < DEPTH_W);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign redirect_pc_aligned = redirect_pc & 32'hFFFF_FFFC;

    // Responses belonging to the pre-redirect stream are counted off by drop_cnt.
    assign rsp_keep = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    assign q_empty  = (q_count == '0);
    assign advance  = !flush && !stall;
    assign q_pop    = advance && !q_empty;
    // An empty queue on an advancing cycle lets the response bypass straight into IF/ID.
    assign q_push   = rsp_keep && !(advance && q_empty);

    assign id_pc_plus4 = id_pc + 32'd4;

    // Fetch PC, credit accounting and stale-response bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                pc       <= redirect_pc_aligned;
                rsp_pc   <= redirect_pc_aligned;
                drop_cnt <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (req_fire)
                    pc <= pc + 32'd4;
                if (imem_rsp_valid && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - CW'(1);
                if (rsp_keep)
                    rsp_pc <= rsp_pc + 32'd4;
            end
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue outright.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_head  <= '0;
            q_tail  <= '0;
            q_count <= '0;
        end else if (redirect_valid) begin
            q_head  <= '0;
            q_tail  <= '0;
            q_count <= '0;
        end else begin
            if (q_push)
                q_tail <= q_tail + PW'(1);
            if (q_pop)
                q_head <= q_head + PW'(1);
            q_count <= q_count + CW'(q_push) - CW'(q_pop);
        end
    end

    // Queue storage, tagged with the PC of each kept response.
    always_ff @(posedge clk) begin
        if (q_push) begin
            q_pc[q_tail]    <= rsp_pc;
            q_instr[q_tail] <= imem_rsp_data;
        end
    end

    // IF/ID register: flush beats stall beats advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_pc    <= 32'd0;
            id_instr <= NOP_INSTR;
        end else if (flush) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
        end else if (!stall) begin
            if (!q_empty) begin
                id_valid <= 1'b1;
                id_pc    <= q_pc[q_head];
                id_instr <= q_instr[q_head];
            end else if (rsp_keep) begin
                id_valid <= 1'b1;
                id_pc    <= rsp_pc;
                id_instr <= imem_rsp_data;
            end else begin
                id_valid <= 1'b0;
                id_instr <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with reference model and memory
module tb_fetch_stage;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .DEPTH     (DEPTH),
        .NOP_INSTR (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_instr       (id_instr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: condition violated", name);
    endtask

    // Memory: in-order, one-cycle latency unless held; data = addr ^ mem_xor.
    logic [31:0] mem_q[$];
    bit          mem_hold = 0;
    logic [31:0] mem_xor  = 32'h0;

    initial begin
        logic [31:0] a;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            @(posedge clk);
            #3;
            if (rst) begin
                mem_q.delete();
                imem_rsp_valid = 1'b0;
            end else if (!mem_hold && mem_q.size() > 0) begin
                a = mem_q.pop_front();
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = a ^ mem_xor;
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
        end
    end

    // Reference model: in-flight list with stale marks, instruction queue, IF/ID slot.
    typedef struct { logic [31:0] pc; bit stale; } flight_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } slot_t;
    flight_t     inflight[$];
    slot_t       fq[$];
    logic [31:0] m_pc;
    logic        m_id_valid;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_instr;
    flight_t     f;
    slot_t       s;
    logic        m_exp_rv;
    logic        m_kept;
    logic        m_byp;
    logic [31:0] m_rpc;

    // Compare DUT against the model each cycle, then advance the model across the coming edge.
    always @(negedge clk) begin
        if (rst) begin
            inflight.delete();
            fq.delete();
            m_pc       = 32'h0;
            m_id_valid = 1'b0;
            m_id_pc    = 32'h0;
            m_id_instr = NOP;
            check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
            check("rst_id_valid", {31'b0, id_valid}, 32'd0);
            check("rst_id_pc_plus4", id_pc_plus4, 32'd4);
        end else begin
            m_exp_rv = !redirect_valid && (inflight.size() + fq.size() < DEPTH);
            check("req_valid", {31'b0, imem_req_valid}, {31'b0, m_exp_rv});
            check("req_addr", imem_req_addr, m_pc);
            check("id_valid", {31'b0, id_valid}, {31'b0, m_id_valid});
            check("id_pc", id_pc, m_id_pc);
            check("id_pc_plus4", id_pc_plus4, m_id_pc + 32'd4);
            check("id_instr", id_instr, m_id_instr);

            if (imem_req_valid && imem_req_ready)
                mem_q.push_back(imem_req_addr);

            m_kept = 1'b0;
            m_byp  = 1'b0;
            m_rpc  = 32'h0;
            if (imem_rsp_valid) begin
                if (inflight.size() == 0) begin
                    fail("rsp_without_request");
                end else begin
                    f      = inflight.pop_front();
                    m_kept = !f.stale && !redirect_valid;
                    m_rpc  = f.pc;
                end
            end
            if (flush) begin
                m_id_valid = 1'b0;
                m_id_instr = NOP;
            end else if (!stall) begin
                if (fq.size() > 0) begin
                    s          = fq.pop_front();
                    m_id_valid = 1'b1;
                    m_id_pc    = s.pc;
                    m_id_instr = s.instr;
                end else if (m_kept) begin
                    m_id_valid = 1'b1;
                    m_id_pc    = m_rpc;
                    m_id_instr = imem_rsp_data;
                    m_byp      = 1'b1;
                end else begin
                    m_id_valid = 1'b0;
                    m_id_instr = NOP;
                end
            end
            if (m_kept && !m_byp) begin
                if (fq.size() >= DEPTH)
                    fail("queue_overflow");
                fq.push_back('{pc: m_rpc, instr: imem_rsp_data});
            end
            if (redirect_valid) begin
                fq.delete();
                foreach (inflight[i]) inflight[i].stale = 1'b1;
                m_pc = {redirect_pc[31:2], 2'b00};
            end else if (m_exp_rv && imem_req_ready) begin
                inflight.push_back('{pc: m_pc, stale: 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Directed stimulus with literal pins at the interesting points.
    initial begin
        bit found;
        rst = 1'b1; imem_req_ready = 1'b1; stall = 1'b0; flush = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        cyc(2);
        #1;
        check("pin_rst_id_instr", id_instr, 32'h13);
        check("pin_rst_id_pc", id_pc, 32'h0);
        rst = 1'b0;

        // Streaming from reset: first instruction visible two cycles after first accept.
        cyc(2); #1;
        check("pin_first_valid", {31'b0, id_valid}, 32'd1);
        check("pin_first_pc", id_pc, 32'h0);
        check("pin_first_instr", id_instr, 32'h0);
        cyc(1); #1;
        check("pin_second_pc", id_pc, 32'h4);
        check("pin_second_plus4", id_pc_plus4, 32'h8);
        cyc(4);

        // Hazard stall for three cycles; credit runs out.
        stall = 1'b1;
        cyc(2); #1;
        check("pin_stall_no_req", {31'b0, imem_req_valid}, 32'd0);
        cyc(1);
        stall = 1'b0;
        cyc(6);

        // Redirect with two requests in flight.
        mem_xor  = 32'hA5A5_0000;
        mem_hold = 1;
        cyc(4);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        check("pin_redirect_no_req", {31'b0, imem_req_valid}, 32'd0);
        cyc(1);
        redirect_valid = 1'b0; mem_hold = 0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (!found) begin
                if (id_valid) found = 1;
                else cyc(1);
            end
        end
        if (found) check("pin_redirect_pc", id_pc, 32'h100);
        else fail("redirect_timeout");
        cyc(6);

        // Flush and stall together while the queue holds words.
        stall = 1'b1;
        cyc(2);
        flush = 1'b1;
        cyc(1); #1;
        check("pin_flush_valid", {31'b0, id_valid}, 32'd0);
        check("pin_flush_instr", id_instr, 32'h13);
        flush = 1'b0; stall = 1'b0;
        cyc(6);

        // Memory back-pressure for five cycles.
        imem_req_ready = 1'b0;
        cyc(5); #1;
        check("pin_ready_low_valid", {31'b0, id_valid}, 32'd0);
        check("pin_ready_low_req", {31'b0, imem_req_valid}, 32'd1);
        imem_req_ready = 1'b1;
        cyc(6);

        // Misaligned redirect target and PC wrap.
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0203; flush = 1'b1;
        cyc(1);
        redirect_valid = 1'b0; flush = 1'b0;
        #1;
        check("pin_align_addr", imem_req_addr, 32'h200);
        cyc(6);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; flush = 1'b1;
        cyc(1);
        redirect_valid = 1'b0; flush = 1'b0;
        #1;
        check("pin_wrap_addr_pre", imem_req_addr, 32'hFFFF_FFFC);
        check("pin_wrap_req", {31'b0, imem_req_valid}, 32'd1);
        cyc(1); #1;
        check("pin_wrap_addr_post", imem_req_addr, 32'h0);
        cyc(8);

        // Reset mid-stream takes effect immediately.
        rst = 1'b1;
        #1;
        check("pin_midrst_req", {31'b0, imem_req_valid}, 32'd0);
        check("pin_midrst_valid", {31'b0, id_valid}, 32'd0);
        check("pin_midrst_pc", id_pc, 32'h0);
        check("pin_midrst_instr", id_instr, 32'h13);
        cyc(2);
        rst = 1'b0;
        cyc(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
